// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX/MEM forwarding selects and one-cycle load-use stall.
// Optional load-use stall counter is enabled by defining HAZARD_STAT_EN.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rR1,
  input  logic [4:0] id_rR2,
  input  logic       id_re1,
  input  logic       id_re2,
  input  logic [4:0] id_wR,
  input  logic       id_we,
  input  logic       id_is_load,
  input  logic       flush,
`ifdef HAZARD_STAT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic [1:0] rD1_sel,
  output logic [1:0] rD2_sel,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       bubble_idex
);

  localparam logic [1:0] NO_HAZARD       = 2'd0;
  localparam logic [1:0] HAZARD_1        = 2'd1;
  localparam logic [1:0] HAZARD_2        = 2'd2;
  localparam logic [1:0] LOAD_USE_HAZARD = 2'd3;

  logic [4:0] ex_wr_q, mem_wr_q;
  logic       ex_we_q, ex_ld_q, mem_we_q;
  // Set when the entry now in MEM is a load that just stalled the ID instruction.
  logic       stalled_q;

  logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic       load_use, stall;
  logic [1:0] sel1_d, sel2_d;

  function automatic logic [1:0] pick(input logic ex_hit, input logic ex_ld,
                                      input logic mem_hit, input logic mem_stalled);
    logic [1:0] s;
    s = NO_HAZARD;
    if (ex_hit && !ex_ld)            s = HAZARD_1;
    else if (mem_hit && mem_stalled) s = LOAD_USE_HAZARD;
    else if (mem_hit)                s = HAZARD_2;
    return s;
  endfunction

  always_comb begin
    ex_hit1  = id_re1 && ex_we_q  && (ex_wr_q  == id_rR1) && (id_rR1 != 5'd0);
    ex_hit2  = id_re2 && ex_we_q  && (ex_wr_q  == id_rR2) && (id_rR2 != 5'd0);
    mem_hit1 = id_re1 && mem_we_q && (mem_wr_q == id_rR1) && (id_rR1 != 5'd0);
    mem_hit2 = id_re2 && mem_we_q && (mem_wr_q == id_rR2) && (id_rR2 != 5'd0);
    load_use = ex_ld_q && (ex_hit1 || ex_hit2);
    stall    = load_use && !flush && !rst;

    sel1_d = NO_HAZARD;
    sel2_d = NO_HAZARD;
    if (!stall && !flush) begin
      sel1_d = pick(ex_hit1, ex_ld_q, mem_hit1, stalled_q);
      sel2_d = pick(ex_hit2, ex_ld_q, mem_hit2, stalled_q);
    end
  end

  assign stall_pc    = stall;
  assign stall_ifid  = stall;
  assign bubble_idex = stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wr_q   <= 5'd0;
      ex_we_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      mem_wr_q  <= 5'd0;
      mem_we_q  <= 1'b0;
      stalled_q <= 1'b0;
      rD1_sel   <= NO_HAZARD;
      rD2_sel   <= NO_HAZARD;
    end else begin
      mem_wr_q  <= ex_wr_q;
      mem_we_q  <= ex_we_q;
      stalled_q <= stall;
      rD1_sel   <= sel1_d;
      rD2_sel   <= sel2_d;
      if (stall || flush) begin
        ex_wr_q <= 5'd0;
        ex_we_q <= 1'b0;
        ex_ld_q <= 1'b0;
      end else begin
        ex_wr_q <= id_wR;
        ex_we_q <= id_we;
        ex_ld_q <= id_is_load;
      end
    end
  end

`ifdef HAZARD_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= 32'd0;
    else     stall_cnt <= stall_cnt + 32'(stall);
  end
`endif

endmodule
